// File: rtl/ascon_permutation_core.sv
// ascon_permutation_core
//
// Iterative Ascon-p[nr] permutation engine. A 320-bit state and a round
// count are captured on an accepted start. The engine then applies one
// round per clock until the round with index 15 has been applied. Each
// round does constant addition, the 5-bit S-box layer and linear diffusion.
//
// Optional build macro:
//   ASCON_PERM_UNROLL2_EN - apply two rounds (rnd, rnd+1) per RUN cycle.
//                           For odd nr the first RUN cycle applies a
//                           single round, so the last pair ends on rnd=15.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   permutation request, sampled only when idle
//   nr_i     in   round count; 0 gives an immediate done, >16 clamps to 16
//   state_i  in   input state, captured on the accepting edge
//   state_o  out  working / result state register
//   rnd_o    out  round index applied this cycle; 0 when idle
//   busy_o   out  high while rounds execute
//   done_o   out  one-cycle pulse; the result is valid on state_o

package ascon_pkg;
    // Word 0 (bits 63:0) is x0.
    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;
endpackage

module ascon_permutation_core
    import ascon_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [4:0]   nr_i,
    input  ascon_state_t state_i,
    output ascon_state_t state_o,
    output rnd_t         rnd_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic {IDLE, RUN} fsm_e;

    fsm_e         fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    rnd_t         rnd_q, rnd_d;
    logic         done_q, done_d;
    logic [4:0]   nr_eff;
    logic [4:0]   rnd_full;
    rnd_t         rnd_start;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_state_t ascon_round(input ascon_state_t s, input rnd_t r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [7:0]  rc;
        // Constant for index r: high nibble (3-r) mod 16, low nibble (12+r) mod 16,
        // giving 0x3c, 0x2d, ..., 0xf0 (r=4), ..., 0x4b (r=15).
        rc = {4'd3 - r, 4'd12 + r};
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, rc};
        x3 = s[3];
        x4 = s[4];
        // Bit-sliced S-box
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // Linear diffusion
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    assign nr_eff    = (nr_i > 5'd16) ? 5'd16 : nr_i;
    assign rnd_full  = 5'd16 - nr_eff;
    assign rnd_start = rnd_full[3:0];

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    rnd_d   = rnd_start;
                    if (nr_eff == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
`ifdef ASCON_PERM_UNROLL2_EN
                // An odd index can only occur on the first cycle of an odd-nr
                // permutation; it gets a single round to align the pairs.
                if (rnd_q[0]) begin
                    state_d = ascon_round(state_q, rnd_q);
                    rnd_d   = rnd_q + 4'd1;
                    if (rnd_q == 4'd15) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ascon_round(ascon_round(state_q, rnd_q), rnd_q + 4'd1);
                    rnd_d   = rnd_q + 4'd2;
                    if (rnd_q == 4'd14) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end
`else
                state_d = ascon_round(state_q, rnd_q);
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == 4'd15) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
`endif
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == RUN);
    assign rnd_o   = busy_o ? rnd_q : '0;
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_core.sv
module tb_ascon_permutation_core;
    import ascon_pkg::*;

`ifdef ASCON_PERM_UNROLL2_EN
    localparam bit UNROLL = 1'b1;
`else
    localparam bit UNROLL = 1'b0;
`endif

    // Ascon S-box as a lookup table, index {x0,x1,x2,x3,x4} with x0 as MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam logic [7:0] RC [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [4:0]   nr_in;
    ascon_state_t state_in;
    ascon_state_t state_out;
    rnd_t         rnd_out;
    logic         busy;
    logic         done;

    int n_assert;
    int n_fail;

    ascon_permutation_core dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .nr_i    (nr_in),
        .state_i (state_in),
        .state_o (state_out),
        .rnd_o   (rnd_out),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic ascon_state_t ref_perm(input ascon_state_t s, input int nr);
        logic [63:0] x [5];
        logic [4:0]  idx;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[i];
        for (int r = 16 - nr; r < 16; r++) begin
            x[2] = x[2] ^ {56'd0, RC[r]};
            for (int b = 0; b < 64; b++) begin
                idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[idx];
                x[0][b] = o[4];
                x[1][b] = o[3];
                x[2][b] = o[2];
                x[3][b] = o[1];
                x[4][b] = o[0];
            end
            x[0] = x[0] ^ ref_rotr(x[0], 19) ^ ref_rotr(x[0], 28);
            x[1] = x[1] ^ ref_rotr(x[1], 61) ^ ref_rotr(x[1], 39);
            x[2] = x[2] ^ ref_rotr(x[2], 1)  ^ ref_rotr(x[2], 6);
            x[3] = x[3] ^ ref_rotr(x[3], 10) ^ ref_rotr(x[3], 17);
            x[4] = x[4] ^ ref_rotr(x[4], 7)  ^ ref_rotr(x[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_state"}, state_out, '0);
        chk({tag, "_rnd"}, {316'd0, rnd_out}, '0);
        chk({tag, "_busy"}, {319'd0, busy}, '0);
        chk({tag, "_done"}, {319'd0, done}, '0);
    endtask

    // One full permutation with start pulsed for a single edge; checks the
    // busy window, the rnd_o sequence, the done pulse and the held result.
    task automatic run_perm(input string tag, input ascon_state_t st, input logic [4:0] nr);
        int           nr_eff;
        int           nb;
        logic [3:0]   r;
        logic [4:0]   r5;
        ascon_state_t exp_s;
        nr_eff = (nr > 5'd16) ? 16 : int'(nr);
        nb     = UNROLL ? (nr_eff + 1) / 2 : nr_eff;
        exp_s  = ref_perm(st, nr_eff);
        r5     = 5'(16 - nr_eff);
        r      = r5[3:0];
        @(negedge clk);
        start    = 1'b1;
        state_in = st;
        nr_in    = nr;
        @(negedge clk);
        start    = 1'b0;
        state_in = ~st;
        nr_in    = 5'd3;
        for (int c = 0; c < nb; c++) begin
            chk({tag, "_busy"}, {319'd0, busy}, 320'd1);
            chk({tag, "_rnd"}, {316'd0, rnd_out}, {316'd0, r});
            chk({tag, "_nodone"}, {319'd0, done}, '0);
            if (UNROLL && !r[0]) r = r + 4'd2;
            else                 r = r + 4'd1;
            @(negedge clk);
        end
        chk({tag, "_done"}, {319'd0, done}, 320'd1);
        chk({tag, "_idle"}, {319'd0, busy}, '0);
        chk({tag, "_rnd0"}, {316'd0, rnd_out}, '0);
        chk({tag, "_result"}, state_out, exp_s);
        @(negedge clk);
        chk({tag, "_pulse"}, {319'd0, done}, '0);
        chk({tag, "_hold"}, state_out, exp_s);
    endtask

    ascon_state_t st_a;
    ascon_state_t st_b;
    ascon_state_t st_c;
    int           nb12;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        nr_in    = 5'd0;
        state_in = '0;
        nb12     = UNROLL ? 6 : 12;
        st_a = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d};
        st_b = {64'h243f6a8885a308d3, 64'h13198a2e03707344, 64'ha4093822299f31d0,
                64'h082efa98ec4e6c89, 64'h452821e638d01377};
        st_c = {64'hb7e151628aed2a6a, 64'hbf7158809cf4f3c7, 64'h62e7160f38b4da56,
                64'ha784d9045190cfef, 64'h324e7738926cfbe5};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");

        // Ascon-p[12] on all-zero state, rnd 4..15
        run_perm("p12_zero", '0, 5'd12);
        // nr = 8 and 16 on non-trivial states, odd nr = 7 and nr = 1
        run_perm("p8", st_a, 5'd8);
        run_perm("p16", st_b, 5'd16);
        run_perm("p7", st_c, 5'd7);
        run_perm("p1", st_a, 5'd1);
        // nr = 0 gives an immediate done with the captured state
        run_perm("p0", st_c, 5'd0);
        // nr = 20 clamps to 16
        run_perm("p20", st_b, 5'd20);
        chk("p20_vs_p16", state_out, ref_perm(st_b, 16));

        // start held high: chained permutations, RUN-time start ignored,
        // state_i/nr_i ignored except on the accepting edge
        @(negedge clk);
        start    = 1'b1;
        state_in = st_a;
        nr_in    = 5'd12;
        for (int k = 1; k <= nb12; k++) begin
            @(negedge clk);
            chk("chain1_busy", {319'd0, busy}, 320'd1);
            chk("chain1_nodone", {319'd0, done}, '0);
            state_in = st_c ^ ascon_state_t'(k);
            nr_in    = 5'd1;
        end
        @(negedge clk);
        chk("chain1_done", {319'd0, done}, 320'd1);
        chk("chain1_result", state_out, ref_perm(st_a, 12));
        state_in = st_b;
        nr_in    = 5'd12;
        for (int k = 1; k <= nb12; k++) begin
            @(negedge clk);
            chk("chain2_busy", {319'd0, busy}, 320'd1);
            state_in = st_a ^ ascon_state_t'(k);
            nr_in    = 5'd2;
        end
        @(negedge clk);
        chk("chain2_done", {319'd0, done}, 320'd1);
        chk("chain2_result", state_out, ref_perm(st_b, 12));
        start = 1'b0;
        nr_in = 5'd12;
        @(negedge clk);
        chk("chain_stop", {319'd0, busy}, '0);
        chk("chain_stop_hold", state_out, ref_perm(st_b, 12));

        // Reset asserted in RUN cycle 5 aborts asynchronously
        start    = 1'b1;
        state_in = st_c;
        nr_in    = 5'd12;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {319'd0, busy}, 320'd1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("abort_nodone", {319'd0, done}, '0);
        end
        run_perm("after_abort", st_c, 5'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
